// File: rtl/lii_pkg.sv
// Shared LII packet encodings and FSM state types for the AXI-MM to LII bridge.
package lii_pkg;

  localparam int OP_W   = 2;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;
  localparam int TAG_W  = 8;
  localparam int RESP_W = 2;

  localparam logic [OP_W-1:0] OP_READ       = 2'b00;
  localparam logic [OP_W-1:0] OP_WRITE      = 2'b01;
  localparam logic [OP_W-1:0] OP_READ_RESP  = 2'b10;
  localparam logic [OP_W-1:0] OP_WRITE_RESP = 2'b11;

  typedef logic [1:0] qstate_t;
  localparam qstate_t Q_IDLE   = 2'd0;
  localparam qstate_t Q_HDR_RD = 2'd1;
  localparam qstate_t Q_HDR_WR = 2'd2;
  localparam qstate_t Q_SEND_W = 2'd3;

  typedef logic pstate_t;
  localparam pstate_t P_HDR   = 1'b0;
  localparam pstate_t P_RDATA = 1'b1;

  // Width of the request header fields packed at the top of a flit.
  function automatic int req_hdr_w(input int aw);
    return OP_W + LEN_W + SIZE_W + aw + TAG_W;
  endfunction

endpackage

// File: rtl/lii_outst_ctr.sv
// Up/down outstanding-transaction counter that saturates at MAX and never underflows.
module lii_outst_ctr #(
  parameter int MAX = 4,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] count_q, count_d;

  assign full_o  = (count_q == W'(MAX));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Simultaneous inc and dec cancel; both directions clamp at their limits.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !full_o) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && !empty_o) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/aximm_lii_bridge.sv
// AXI4 slave to LII flit-stream bridge: AR/AW become header flits, W beats become
// data flits, and LII response packets are unpacked onto the B and R channels.
module aximm_lii_bridge
  import lii_pkg::*;
#(
  parameter int AXI_AW    = 48,
  parameter int AXI_DW    = 256,
  parameter int LII_DW    = 512,
  parameter int MAX_OUTST = 4
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic [AXI_AW-1:0]     aximm_araddr,
  input  logic [7:0]            aximm_arlen,
  input  logic [2:0]            aximm_arsize,
  input  logic                  aximm_arvalid,
  output logic                  aximm_arready,

  input  logic [AXI_AW-1:0]     aximm_awaddr,
  input  logic [7:0]            aximm_awlen,
  input  logic [2:0]            aximm_awsize,
  input  logic                  aximm_awvalid,
  output logic                  aximm_awready,

  input  logic [AXI_DW-1:0]     aximm_wdata,
  input  logic [AXI_DW/8-1:0]   aximm_wstrb,
  input  logic                  aximm_wlast,
  input  logic                  aximm_wvalid,
  output logic                  aximm_wready,

  output logic [1:0]            aximm_bresp,
  output logic                  aximm_bvalid,
  input  logic                  aximm_bready,

  output logic [AXI_DW-1:0]     aximm_rdata,
  output logic [1:0]            aximm_rresp,
  output logic                  aximm_rlast,
  output logic                  aximm_rvalid,
  input  logic                  aximm_rready,

  output logic [LII_DW-1:0]     lii_req_tdata,
  output logic [LII_DW/8-1:0]   lii_req_tkeep,
  output logic [LII_DW/8-1:0]   lii_req_tstrb,
  output logic                  lii_req_tlast,
  output logic [7:0]            lii_req_src,
  output logic [7:0]            lii_req_dst,
  output logic                  lii_req_tvalid,
  input  logic                  lii_req_tready,

  input  logic [LII_DW-1:0]     lii_resp_tdata,
  input  logic [LII_DW/8-1:0]   lii_resp_tkeep,
  input  logic [LII_DW/8-1:0]   lii_resp_tstrb,
  input  logic                  lii_resp_tlast,
  input  logic [7:0]            lii_resp_src,
  input  logic [7:0]            lii_resp_dst,
  input  logic                  lii_resp_tvalid,
  output logic                  lii_resp_tready,

  input  logic [7:0]            cfg_src,
  input  logic [7:0]            cfg_dst,
  output logic [3:0]            rd_outst,
  output logic [3:0]            wr_outst
);

  localparam int HDR_W = req_hdr_w(AXI_AW);
  localparam int SW    = AXI_DW / 8;
  localparam int KW    = LII_DW / 8;

  qstate_t             qs_q, qs_d;
  pstate_t             ps_q, ps_d;
  logic                prio_ar_q, prio_ar_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [TAG_W-1:0]    req_tag_q, req_tag_d;
  logic [AXI_AW-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [RESP_W-1:0]   resp_q, resp_d;

  logic rd_full, wr_full, rd_empty, wr_empty;
  logic ar_ok, aw_ok, grant_ar, grant_aw;
  logic ar_hs, aw_hs, w_hs, req_hs, b_hs, r_done;

  logic [LII_DW-1:0] hdr_data;
  logic [LII_DW-1:0] w_data;
  logic [KW-1:0]     w_keep;
  logic [OP_W-1:0]   resp_op;
  logic [RESP_W-1:0] resp_code;

  // Round-robin: prio_ar_q set means AR wins a tie; cleared after reset so AW goes first.
  assign ar_ok    = aximm_arvalid && !rd_full;
  assign aw_ok    = aximm_awvalid && !wr_full;
  assign grant_ar = ar_ok && (!aw_ok || prio_ar_q);
  assign grant_aw = aw_ok && !grant_ar;

  assign aximm_arready = rstn && (qs_q == Q_IDLE) && grant_ar;
  assign aximm_awready = rstn && (qs_q == Q_IDLE) && grant_aw;

  assign ar_hs  = aximm_arvalid && aximm_arready;
  assign aw_hs  = aximm_awvalid && aximm_awready;
  assign w_hs   = aximm_wvalid && aximm_wready;
  assign req_hs = lii_req_tvalid && lii_req_tready;
  assign b_hs   = aximm_bvalid && aximm_bready;
  assign r_done = aximm_rvalid && aximm_rready && aximm_rlast;

  assign lii_req_src = cfg_src;
  assign lii_req_dst = cfg_dst;

  always_comb begin
    hdr_data = '0;
    hdr_data[LII_DW-1 -: HDR_W] = {(qs_q == Q_HDR_WR) ? OP_WRITE : OP_READ,
                                   len_q, size_q, addr_q, req_tag_q};
    w_data = '0;
    w_data[AXI_DW-1:0] = aximm_wdata;
    w_keep = '0;
    w_keep[SW-1:0] = aximm_wstrb;
  end

  always_comb begin
    lii_req_tvalid = 1'b0;
    lii_req_tdata  = '0;
    lii_req_tkeep  = '0;
    lii_req_tstrb  = '0;
    lii_req_tlast  = 1'b0;
    aximm_wready   = 1'b0;
    case (qs_q)
      Q_HDR_RD, Q_HDR_WR: begin
        lii_req_tvalid = 1'b1;
        lii_req_tdata  = hdr_data;
        lii_req_tkeep  = '1;
        lii_req_tlast  = (qs_q == Q_HDR_RD);
      end
      Q_SEND_W: begin
        lii_req_tvalid = aximm_wvalid;
        lii_req_tdata  = w_data;
        lii_req_tkeep  = w_keep;
        lii_req_tstrb  = w_keep;
        lii_req_tlast  = aximm_wlast;
        aximm_wready   = lii_req_tready;
      end
      default: ;
    endcase
    if (!rstn) begin
      lii_req_tvalid = 1'b0;
      aximm_wready   = 1'b0;
    end
  end

  always_comb begin
    qs_d      = qs_q;
    prio_ar_d = prio_ar_q;
    tag_d     = tag_q;
    req_tag_d = req_tag_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    case (qs_q)
      Q_IDLE: begin
        if (ar_hs) begin
          qs_d      = Q_HDR_RD;
          prio_ar_d = 1'b0;
          addr_d    = aximm_araddr;
          len_d     = aximm_arlen;
          size_d    = aximm_arsize;
          req_tag_d = tag_q;
          tag_d     = tag_q + 8'd1;
        end else if (aw_hs) begin
          qs_d      = Q_HDR_WR;
          prio_ar_d = 1'b1;
          addr_d    = aximm_awaddr;
          len_d     = aximm_awlen;
          size_d    = aximm_awsize;
          req_tag_d = tag_q;
          tag_d     = tag_q + 8'd1;
        end
      end
      Q_HDR_RD: if (req_hs) qs_d = Q_IDLE;
      Q_HDR_WR: if (req_hs) qs_d = Q_SEND_W;
      Q_SEND_W: if (w_hs && aximm_wlast) qs_d = Q_IDLE;
      default:  qs_d = Q_IDLE;
    endcase
  end

  assign resp_op   = lii_resp_tdata[LII_DW-1 -: OP_W];
  assign resp_code = lii_resp_tdata[LII_DW-1-OP_W-TAG_W -: RESP_W];

  // A write-response header is held on the stream until B is accepted; any other
  // header is taken immediately (unknown ops are simply dropped).
  always_comb begin
    ps_d            = ps_q;
    resp_d          = resp_q;
    lii_resp_tready = 1'b0;
    aximm_bvalid    = 1'b0;
    aximm_bresp     = resp_code;
    aximm_rvalid    = 1'b0;
    aximm_rdata     = lii_resp_tdata[AXI_DW-1:0];
    aximm_rresp     = resp_q;
    aximm_rlast     = lii_resp_tlast;
    if (ps_q == P_HDR) begin
      if (lii_resp_tvalid && resp_op == OP_WRITE_RESP) begin
        aximm_bvalid    = 1'b1;
        lii_resp_tready = aximm_bready;
      end else begin
        lii_resp_tready = 1'b1;
      end
      if (lii_resp_tvalid && resp_op == OP_READ_RESP) begin
        ps_d   = P_RDATA;
        resp_d = resp_code;
      end
    end else begin
      aximm_rvalid    = lii_resp_tvalid;
      lii_resp_tready = aximm_rready;
      if (lii_resp_tvalid && aximm_rready && lii_resp_tlast) ps_d = P_HDR;
    end
    if (!rstn) begin
      lii_resp_tready = 1'b0;
      aximm_bvalid    = 1'b0;
      aximm_rvalid    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      qs_q      <= Q_IDLE;
      ps_q      <= P_HDR;
      prio_ar_q <= 1'b0;
      tag_q     <= '0;
      req_tag_q <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      resp_q    <= '0;
    end else begin
      qs_q      <= qs_d;
      ps_q      <= ps_d;
      prio_ar_q <= prio_ar_d;
      tag_q     <= tag_d;
      req_tag_q <= req_tag_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      resp_q    <= resp_d;
    end
  end

  lii_outst_ctr #(.MAX(MAX_OUTST), .W(4)) u_rd_ctr (
    .clk     (clk),
    .rstn    (rstn),
    .inc_i   (ar_hs),
    .dec_i   (r_done),
    .count_o (rd_outst),
    .full_o  (rd_full),
    .empty_o (rd_empty)
  );

  lii_outst_ctr #(.MAX(MAX_OUTST), .W(4)) u_wr_ctr (
    .clk     (clk),
    .rstn    (rstn),
    .inc_i   (aw_hs),
    .dec_i   (b_hs),
    .count_o (wr_outst),
    .full_o  (wr_full),
    .empty_o (wr_empty)
  );

  // Response sideband fields carry nothing the AXI side needs.
  logic unused_resp;
  assign unused_resp = ^{lii_resp_tdata, lii_resp_tkeep, lii_resp_tstrb,
                         lii_resp_src, lii_resp_dst, rd_empty, wr_empty};

endmodule
